// File: rtl/ixc_uclk_div.sv
// Programmable uclk divider: produces dclk with runtime high/low phase lengths plus
// one-cycle pos_en/neg_en enables. Optional free-running counter under IXC_UCLK_CYC_CNT_EN.
module ixc_uclk_div #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             uclk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] hi_cnt,
    input  logic [CNT_W-1:0] lo_cnt,
    input  logic             run_req,
    output logic             run_ack,
    output logic             dclk,
    output logic             pos_en,
    output logic             neg_en
`ifdef IXC_UCLK_CYC_CNT_EN
    ,
    output logic [31:0]      cyc_cnt
`endif
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hi_load;
    logic [CNT_W-1:0] lo_load;

    // Counter holds (phase length - 1); a zero length behaves as one cycle.
    always_comb begin
        hi_load = (hi_cnt == '0) ? '0 : hi_cnt - CntOne;
        lo_load = (lo_cnt == '0) ? '0 : lo_cnt - CntOne;
    end

    always_ff @(posedge uclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dclk    <= 1'b0;
            pos_en  <= 1'b0;
            neg_en  <= 1'b0;
            run_ack <= 1'b0;
        end else begin
            pos_en <= 1'b0;
            neg_en <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (run_req) begin
                        state_q <= StHigh;
                        dclk    <= 1'b1;
                        pos_en  <= 1'b1;
                        run_ack <= 1'b1;
                        cnt_q   <= hi_load;
                    end else begin
                        dclk    <= 1'b0;
                        run_ack <= 1'b0;
                    end
                end
                StHigh: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntOne;
                    end else begin
                        state_q <= StLow;
                        dclk    <= 1'b0;
                        neg_en  <= 1'b1;
                        cnt_q   <= lo_load;
                    end
                end
                StLow: begin
                    // run_req only matters once the low phase has fully elapsed.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntOne;
                    end else if (run_req) begin
                        state_q <= StHigh;
                        dclk    <= 1'b1;
                        pos_en  <= 1'b1;
                        cnt_q   <= hi_load;
                    end else begin
                        state_q <= StIdle;
                        run_ack <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    dclk    <= 1'b0;
                    run_ack <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef IXC_UCLK_CYC_CNT_EN
    always_ff @(posedge uclk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ixc_uclk_div.sv
// Bench for ixc_uclk_div: directed vector table, hand-written corner sequences and a
// randomized run against a queue-based waveform model.
module tb_ixc_uclk_div;

    localparam int unsigned CNT_W = 16;

    logic             uclk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] lo_cnt;
    logic             run_req;
    logic             run_ack;
    logic             dclk;
    logic             pos_en;
    logic             neg_en;
`ifdef IXC_UCLK_CYC_CNT_EN
    logic [31:0]      cyc_cnt;
`endif

    ixc_uclk_div #(.CNT_W(CNT_W)) dut (
        .uclk    (uclk),
        .rst_n   (rst_n),
        .hi_cnt  (hi_cnt),
        .lo_cnt  (lo_cnt),
        .run_req (run_req),
        .run_ack (run_ack),
        .dclk    (dclk),
        .pos_en  (pos_en),
        .neg_en  (neg_en)
`ifdef IXC_UCLK_CYC_CNT_EN
        ,
        .cyc_cnt (cyc_cnt)
`endif
    );

    always #5 uclk = ~uclk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [CNT_W-1:0] hi;
        logic [CNT_W-1:0] lo;
        logic             run;
        logic [3:0]       exp; // {dclk, pos_en, neg_en, run_ack}
    } vec_t;

    vec_t tbl[20];

    // Model: a queue of future output samples, filled one whole phase at a time.
    logic [3:0] mq[$];
    bit         last_high;
    logic [3:0] m_exp;

    function automatic logic [3:0] outs();
        return {dclk, pos_en, neg_en, run_ack};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        last_high = 1'b0;
    endtask

    // Evaluated with the inputs as they stood at the edge just taken.
    task automatic model_step();
        int he;
        int le;
        he = (hi_cnt == 0) ? 1 : int'(hi_cnt);
        le = (lo_cnt == 0) ? 1 : int'(lo_cnt);
        if (mq.size() == 0) begin
            if (last_high) begin
                for (int i = 0; i < le; i++) mq.push_back((i == 0) ? 4'b0011 : 4'b0001);
                last_high = 1'b0;
            end else if (run_req) begin
                for (int i = 0; i < he; i++) mq.push_back((i == 0) ? 4'b1101 : 4'b1001);
                last_high = 1'b1;
            end
        end
        m_exp = (mq.size() == 0) ? 4'b0000 : mq.pop_front();
    endtask

    task automatic step();
        @(posedge uclk);
        #1;
    endtask

    task automatic do_reset();
        run_req = 1'b0;
        rst_n   = 1'b0;
        #1;
        rst_n   = 1'b1;
        model_reset();
    endtask

    task automatic set_vec(input int i, input int hi, input int lo, input logic run,
                           input logic [3:0] exp);
        tbl[i].hi  = CNT_W'(hi);
        tbl[i].lo  = CNT_W'(lo);
        tbl[i].run = run;
        tbl[i].exp = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] e;
        // Period 5 (hi=2, lo=3), stop requested mid-high, then zero-clamped period 2.
        for (int i = 0; i < 12; i++) begin
            case (i % 5)
                0:       e = 4'b1101;
                1:       e = 4'b1001;
                2:       e = 4'b0011;
                default: e = 4'b0001;
            endcase
            set_vec(i, 2, 3, 1'b1, e);
        end
        set_vec(12, 2, 3, 1'b0, 4'b0011);
        set_vec(13, 2, 3, 1'b0, 4'b0001);
        set_vec(14, 2, 3, 1'b0, 4'b0001);
        set_vec(15, 2, 3, 1'b0, 4'b0000);
        set_vec(16, 0, 0, 1'b1, 4'b1101);
        set_vec(17, 0, 0, 1'b1, 4'b0011);
        set_vec(18, 0, 0, 1'b1, 4'b1101);
        set_vec(19, 0, 0, 1'b1, 4'b0011);

        rst_n   = 1'b0;
        run_req = 1'b0;
        hi_cnt  = '0;
        lo_cnt  = '0;
        model_reset();
        #1;
        check("reset_outs", 32'(outs()), 32'h0);
`ifdef IXC_UCLK_CYC_CNT_EN
        check("reset_cyc", cyc_cnt, 32'h0);
`endif
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) step();
        check("idle_outs", 32'(outs()), 32'h0);
`ifdef IXC_UCLK_CYC_CNT_EN
        check("cyc_after_7", cyc_cnt, 32'd7);
`endif

        // Directed table
        for (int i = 0; i < 20; i++) begin
            hi_cnt  = tbl[i].hi;
            lo_cnt  = tbl[i].lo;
            run_req = tbl[i].run;
            step();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Stop requested in the second high cycle: both phases still complete.
        do_reset();
        hi_cnt  = 4;
        lo_cnt  = 4;
        run_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            e = {c <= 4, c == 1, c == 5, c <= 8};
            check($sformatf("stop_c%0d", c), 32'(outs()), 32'(e));
            if (c == 2) run_req = 1'b0;
        end

        // Reprogram hi_cnt during a low phase.
        do_reset();
        hi_cnt  = 3;
        lo_cnt  = 3;
        run_req = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            step();
            e = {(c <= 3) || (c == 7) || (c == 11), (c == 1) || (c == 7) || (c == 11),
                 (c == 4) || (c == 8), 1'b1};
            check($sformatf("reprog_c%0d", c), 32'(outs()), 32'(e));
            if (c == 4) hi_cnt = 1;
        end

        // Asynchronous reset during HIGH.
        do_reset();
        hi_cnt  = 4;
        lo_cnt  = 4;
        run_req = 1'b1;
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(outs()), 32'h0);
        rst_n = 1'b1;
        step();
        check("rst_restart", 32'(outs()), 32'hd);
        step();
        check("rst_restart2", 32'(outs()), 32'h9);

`ifdef IXC_UCLK_CYC_CNT_EN
        force dut.cyc_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.cyc_cnt;
        step();
        check("cyc_ffff", cyc_cnt, 32'hFFFF_FFFF);
        step();
        check("cyc_wrap", cyc_cnt, 32'h0);
`endif

        // Randomized run against the model
        do_reset();
        hi_cnt  = 2;
        lo_cnt  = 1;
        run_req = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) hi_cnt = CNT_W'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) lo_cnt = CNT_W'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) run_req = ~run_req;
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rnd_rst", 32'(outs()), 32'h0);
                rst_n = 1'b1;
                model_reset();
            end
            @(posedge uclk);
            model_step();
            #1;
            check("rnd", 32'(outs()), 32'(m_exp));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
